// File: rtl/deserializador_coma_pkg.sv
// Shared link-layer definitions: K28.5 comma patterns, symbol framing constants
// and the receiver alignment state encoding.
package deserializador_coma_pkg;

  localparam logic [9:0] K28_5_NEG  = 10'b0011111010;
  localparam logic [9:0] K28_5_POS  = 10'b1100000101;
  localparam int         SYMBOL_BITS = 10;
  localparam logic [3:0] PHASE_LAST = 4'd10;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } linkStateT;

  // phase counts 1..10 bits of the symbol currently held in the shift register
  function automatic logic [3:0] nextPhase(input logic [3:0] phaseNow);
    return (phaseNow == PHASE_LAST) ? 4'd1 : phaseNow + 4'd1;
  endfunction

endpackage

// File: rtl/deserializador_coma_detector.sv
// Comma detector: flags a 10-bit window equal to either running-disparity
// form of K28.5.
module deserializador_coma_detector
  import deserializador_coma_pkg::*;
#(
  parameter logic [9:0] COMMA_NEG = K28_5_NEG,
  parameter logic [9:0] COMMA_POS = K28_5_POS
) (
  input  logic [SYMBOL_BITS-1:0] word,
  output logic                   commaHit
);

  localparam logic [1:0][9:0] COMMAS = {COMMA_POS, COMMA_NEG};

  logic [1:0] matchVec;

  for (genvar gi = 0; gi < 2; gi++) begin : gMatch
    assign matchVec[gi] = (word == COMMAS[gi]);
  end

  assign commaHit = |matchVec;

endmodule

// File: rtl/deserializador_coma.sv
// Serial-to-symbol front end: shifts in the line, finds the 10-bit boundary on a
// K28.5 comma and emits aligned symbols while tracking lock.
module deserializador_coma
  import deserializador_coma_pkg::*;
#(
  parameter logic [9:0] COMMA_NEG    = K28_5_NEG,
  parameter logic [9:0] COMMA_POS    = K28_5_POS,
  parameter int         MISALIGN_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] symbolOut,
  output logic       symbolValid,
  output logic       isComma,
  output logic       locked,
  output logic       alignErr
);

  localparam logic [2:0] MISS_LIMIT = 3'(MISALIGN_MAX);

  linkStateT  state;
  logic [9:0] shiftReg;
  logic [3:0] phase;
  logic [2:0] missCnt;
  logic [2:0] missInc;
  logic       commaHit;

  deserializador_coma_detector #(
    .COMMA_NEG (COMMA_NEG),
    .COMMA_POS (COMMA_POS)
  ) uDetector (
    .word     (shiftReg),
    .commaHit (commaHit)
  );

  assign missInc = missCnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      shiftReg    <= '0;
      phase       <= '0;
      missCnt     <= '0;
      symbolOut   <= '0;
      symbolValid <= 1'b0;
      isComma     <= 1'b0;
      locked      <= 1'b0;
      alignErr    <= 1'b0;
    end else begin
      symbolValid <= 1'b0;
      isComma     <= 1'b0;
      alignErr    <= 1'b0;
      if (enb) begin
        shiftReg <= {shiftReg[8:0], serialIn};
        case (state)
          HUNT: begin
            if (commaHit) begin
              symbolOut   <= shiftReg;
              symbolValid <= 1'b1;
              isComma     <= 1'b1;
              phase       <= 4'd1;
              missCnt     <= '0;
              locked      <= 1'b1;
              state       <= LOCKED;
            end
          end
          LOCKED: begin
            phase <= nextPhase(phase);
            if (phase == PHASE_LAST) begin
              symbolOut   <= shiftReg;
              symbolValid <= 1'b1;
              isComma     <= commaHit;
              if (commaHit) begin
                missCnt <= '0;
              end
            end else if (commaHit) begin
              // off-boundary comma: counted only, the boundary never moves here
              alignErr <= 1'b1;
              if (missInc == MISS_LIMIT) begin
                state   <= HUNT;
                locked  <= 1'b0;
                missCnt <= '0;
              end else begin
                missCnt <= missInc;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
